// File: rtl/afifo_pkg.sv
// Shared types and helpers for the async-FIFO write-side arbiter.
package afifo_pkg;

   localparam int unsigned STALL_CNT_W = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Index width for n items, never narrower than one bit
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n < 2) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ.
module rr_pick
   import afifo_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]             req,
   input  logic [clog2_min1(NREQ)-1:0] ptr,
   output logic                        any,
   output logic [clog2_min1(NREQ)-1:0] idx
);

   localparam int unsigned IW = clog2_min1(NREQ);

   logic [IW-1:0] cand;
   logic          found;

   // Lowest offset from ptr wins; modulo keeps cand below NREQ for any NREQ
   always_comb begin
      any   = |req;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IW'((32'(ptr) + k) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/afifo_wr_arb.sv
// Round-robin, burst-limited arbiter sharing one async-FIFO write port (wclk domain).
// Optional stall counter (stall_cnt/stall_clr ports) enabled by AFIFO_WR_ARB_STALL_CNT_EN.
module afifo_wr_arb
   import afifo_pkg::*;
#(
   parameter int unsigned DSIZE    = 8,
   parameter int unsigned ASIZE    = 4,
   parameter int unsigned NREQ     = 4,
   parameter int unsigned MAXBURST = 4
) (
   input  logic                        wclk,
   input  logic                        wrst_n,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [NREQ*DSIZE-1:0]       req_data,
   output logic [NREQ-1:0]             req_ready,
   input  logic                        full,
   output logic                        wen,
   output logic [DSIZE-1:0]            wdata,
   output logic [clog2_min1(NREQ)-1:0] gnt_id,
   output logic                        busy
`ifdef AFIFO_WR_ARB_STALL_CNT_EN
   ,
   input  logic                        stall_clr,
   output logic [STALL_CNT_W-1:0]      stall_cnt
`endif
);

   localparam int unsigned IDW        = clog2_min1(NREQ);
   localparam int unsigned FIFO_DEPTH = 32'd1 << ASIZE;
   localparam int unsigned BURST_MAX  = (MAXBURST < FIFO_DEPTH) ? MAXBURST : FIFO_DEPTH;
   localparam int unsigned BCW        = $clog2(BURST_MAX + 1);

   arb_state_t     state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic [BCW-1:0] burst_cnt_q, burst_cnt_d;

   logic           pick_any;
   logic [IDW-1:0] pick_idx;
   logic [IDW-1:0] gnt_next;
   logic           sel_valid;
   logic           xfer;
   logic           last_beat;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign sel_valid = req_valid[gnt_id_q];
   assign xfer      = (state_q == GRANT) && sel_valid && !full;
   assign last_beat = (burst_cnt_q == BCW'(BURST_MAX - 1));
   assign gnt_next  = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);

   // Next-state and write-port decode; full stalls hold the grant and the count
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_id_d    = gnt_id_q;
      burst_cnt_d = burst_cnt_q;
      req_ready   = '0;
      wen         = 1'b0;
      wdata       = '0;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_id_d    = pick_idx;
               burst_cnt_d = '0;
               state_d     = GRANT;
            end
         end

         GRANT: begin
            req_ready[gnt_id_q] = ~full;
            wen                 = xfer;
            for (int unsigned i = 0; i < NREQ; i++) begin
               if (gnt_id_q == IDW'(i)) begin
                  wdata = req_data[i*DSIZE +: DSIZE];
               end
            end
            if (xfer) begin
               burst_cnt_d = burst_cnt_q + BCW'(1);
            end
            if (!sel_valid || (xfer && last_beat)) begin
               state_d  = IDLE;
               rr_ptr_d = gnt_next;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         gnt_id_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_id_q    <= gnt_id_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign gnt_id = gnt_id_q;
   assign busy   = (state_q == GRANT);

`ifdef AFIFO_WR_ARB_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Counts cycles the holder is blocked by full; clear beats increment
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_clr) begin
         stall_cnt_d = '0;
      end else if ((state_q == GRANT) && sel_valid && full && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Scoreboard bench for afifo_wr_arb: directed scenarios plus randomized traffic vs. a rule-level model.
module tb_afifo_wr_arb;

   localparam int DSIZE    = 8;
   localparam int ASIZE    = 4;
   localparam int NREQ     = 4;
   localparam int MAXBURST = 4;
   localparam int GW       = $clog2(NREQ);

   logic                   wclk = 1'b0;
   logic                   wrst_n = 1'b0;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*DSIZE-1:0]  req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   full;
   logic                   wen;
   logic [DSIZE-1:0]       wdata;
   logic [GW-1:0]          gnt_id;
   logic                   busy;
   logic                   stall_clr;
`ifdef AFIFO_WR_ARB_STALL_CNT_EN
   logic [15:0]            stall_cnt;
`endif

   afifo_wr_arb #(
      .DSIZE    (DSIZE),
      .ASIZE    (ASIZE),
      .NREQ     (NREQ),
      .MAXBURST (MAXBURST)
   ) dut (
      .wclk      (wclk),
      .wrst_n    (wrst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .full      (full),
      .wen       (wen),
      .wdata     (wdata),
      .gnt_id    (gnt_id),
      .busy      (busy)
`ifdef AFIFO_WR_ARB_STALL_CNT_EN
      ,
      .stall_clr (stall_clr),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 wclk = ~wclk;

   typedef struct {
      logic            busy;
      logic [GW-1:0]   gnt;
      logic [NREQ-1:0] rdy;
      logic            wen;
      logic [15:0]     stall;
   } cyc_t;

   typedef struct {
      int              src;
      logic [DSIZE-1:0] data;
   } xfer_t;

   cyc_t  exp_cyc_q[$];
   xfer_t exp_x_q[$];

   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b0;

   // requester sources: words still to send and the word on the bus
   int               left[NREQ];
   logic [DSIZE-1:0] dat[NREQ];
   bit               drop[NREQ];

   // reference model: who owns the port, where the next search starts, beats done
   int m_owner;
   int m_ptr;
   int m_done;
   int m_stall;

   int          wen_cnt;
   logic [63:0] wen_hist;
   int          gnt_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_done  = 0;
      m_stall = 0;
   endtask

   task automatic model_cycle(input logic [NREQ-1:0] v, input logic f, input logic clr,
                              output int acc);
      cyc_t  e;
      xfer_t x;
      bit    stalled;
      int    j;
      e.busy  = 1'b0;
      e.gnt   = '0;
      e.rdy   = '0;
      e.wen   = 1'b0;
      e.stall = 16'(m_stall);
      acc     = -1;
      stalled = 1'b0;
      if (m_owner < 0) begin
         for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (v[j] && m_owner < 0) begin
               m_owner = j;
               m_done  = 0;
            end
         end
      end else begin
         e.busy = 1'b1;
         e.gnt  = GW'(m_owner);
         e.rdy[m_owner] = !f;
         stalled = v[m_owner] && f;
         if (v[m_owner] && !f) begin
            e.wen  = 1'b1;
            x.src  = m_owner;
            x.data = dat[m_owner];
            exp_x_q.push_back(x);
            acc = m_owner;
            m_done++;
         end
         if (!v[m_owner] || m_done == MAXBURST) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
         end
      end
      exp_cyc_q.push_back(e);
      if (clr) m_stall = 0;
      else if (stalled && m_stall < 65535) m_stall++;
   endtask

   // one wclk cycle: drive sources, predict, advance to just after the next edge
   task automatic step(input logic f, input logic clr);
      logic [NREQ-1:0] v;
      int acc;
      for (int i = 0; i < NREQ; i++) begin
         v[i] = (left[i] > 0) && !drop[i];
         req_data[i*DSIZE +: DSIZE] = dat[i];
      end
      req_valid = v;
      full      = f;
      stall_clr = clr;
      model_cycle(v, f, clr, acc);
      if (acc >= 0) begin
         left[acc]--;
         dat[acc] = DSIZE'($urandom);
      end
      @(posedge wclk);
      #1;
   endtask

   task automatic clear_log();
      wen_cnt  = 0;
      wen_hist = '0;
      gnt_log.delete();
   endtask

   task automatic set_all(input int n);
      for (int i = 0; i < NREQ; i++) left[i] = n;
   endtask

   function automatic bit all_quiet();
      bit q;
      q = (m_owner < 0);
      for (int i = 0; i < NREQ; i++) if (left[i] != 0) q = 1'b0;
      return q;
   endfunction

   // monitor: per-cycle expectation check, data popped whenever the DUT writes
   always @(negedge wclk) begin
      cyc_t  e;
      xfer_t x;
      if (mon_en) begin
         chk("wen_while_full", 32'(wen & full), 32'd0);
         if (exp_cyc_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL cycle_exp: no expectation queued at %0t", $time);
         end else begin
            e = exp_cyc_q.pop_front();
            chk("busy", 32'(busy), 32'(e.busy));
            chk("req_ready", 32'(req_ready), 32'(e.rdy));
            chk("wen", 32'(wen), 32'(e.wen));
            if (e.busy) chk("gnt_id", 32'(gnt_id), 32'(e.gnt));
`ifdef AFIFO_WR_ARB_STALL_CNT_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
`endif
         end
         wen_hist = {wen_hist[62:0], wen};
         if (wen === 1'b1) begin
            wen_cnt++;
            gnt_log.push_back(int'(gnt_id));
            if (exp_x_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL wr_exp: write of 0x%0h with nothing expected at %0t", wdata, $time);
            end else begin
               x = exp_x_q.pop_front();
               chk("wdata", 32'(wdata), 32'(x.data));
               chk("wr_src", 32'(gnt_id), 32'(x.src));
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         left[i] = 0;
         dat[i]  = DSIZE'($urandom);
         drop[i] = 1'b0;
      end
      req_valid = '0;
      req_data  = '0;
      full      = 1'b0;
      stall_clr = 1'b0;
      model_reset();
      clear_log();

      repeat (2) @(posedge wclk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wen", 32'(wen), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_gnt_id", 32'(gnt_id), 32'd0);
      chk("rst_wdata", 32'(wdata), 32'd0);
`ifdef AFIFO_WR_ARB_STALL_CNT_EN
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      wrst_n = 1'b1;
      mon_en = 1'b1;

      // all requesters continuous: bursts of 4 in order 0,1,2,3,0
      clear_log();
      set_all(1000);
      repeat (25) step(1'b0, 1'b0);
      set_all(0);
      step(1'b0, 1'b0);
      chk("s2_wen_count", 32'(wen_cnt), 32'd20);
      if (gnt_log.size() == 20) begin
         for (int n = 0; n < 20; n++) chk("s2_order", 32'(gnt_log[n]), 32'((n / 4) % 4));
      end else begin
         chk("s2_log_size", 32'(gnt_log.size()), 32'd20);
      end

      // single requester 0: bubbles between bursts
      clear_log();
      left[0] = 10;
      repeat (14) step(1'b0, 1'b0);
      chk("s1_wen_pattern", 32'(wen_hist[13:0]), 32'(14'b01111011110110));
      chk("s1_wen_count", 32'(wen_cnt), 32'd10);

      // requester 2 stalled by full after two beats
      clear_log();
      left[2] = 4;
      for (int c = 0; c < 9; c++) step(c >= 3 && c <= 5, 1'b0);
      chk("s3_wen_pattern", 32'(wen_hist[8:0]), 32'(9'b011000110));
      chk("s3_wen_count", 32'(wen_cnt), 32'd4);
      foreach (gnt_log[n]) chk("s3_src", 32'(gnt_log[n]), 32'd2);

      // requester 1 drops after one beat; 2 must win over 0
      clear_log();
      left[1] = 1;
      for (int c = 0; c < 10; c++) begin
         if (c == 2) begin
            left[0] = 1;
            left[2] = 1;
         end
         step(1'b0, 1'b0);
      end
      chk("s4_log_size", 32'(gnt_log.size()), 32'd3);
      if (gnt_log.size() == 3) begin
         chk("s4_first", 32'(gnt_log[0]), 32'd1);
         chk("s4_second", 32'(gnt_log[1]), 32'd2);
         chk("s4_third", 32'(gnt_log[2]), 32'd0);
      end

      // asynchronous reset in the middle of requester 1's burst
      set_all(1000);
      repeat (3) step(1'b0, 1'b0);
      mon_en = 1'b0;
      #2;
      wrst_n = 1'b0;
      #1;
      chk("arst_wen", 32'(wen), 32'd0);
      chk("arst_req_ready", 32'(req_ready), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_gnt_id", 32'(gnt_id), 32'd0);
      exp_cyc_q.delete();
      exp_x_q.delete();
      model_reset();
      @(posedge wclk);
      #1;
      wrst_n = 1'b1;
      mon_en = 1'b1;
      clear_log();
      repeat (2) step(1'b0, 1'b0);
      chk("s5_restart_src", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 32'd0);
      set_all(0);
      repeat (2) step(1'b0, 1'b0);

`ifdef AFIFO_WR_ARB_STALL_CNT_EN
      // stall counter: five stalled cycles, then clear during a stall
      step(1'b0, 1'b1);
      left[0] = 1;
      step(1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b0);
      chk("s6_stall_5", 32'(stall_cnt), 32'd5);
      step(1'b1, 1'b1);
      chk("s6_stall_clr", 32'(stall_cnt), 32'd0);
      repeat (2) step(1'b0, 1'b0);
`endif

      // randomized traffic with full back-pressure and occasional valid drops
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (left[i] == 0 && $urandom_range(0, 2) == 0) left[i] = int'($urandom_range(1, 6));
            drop[i] = (left[i] > 0) && ($urandom_range(0, 31) == 0);
         end
         step($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
      end
      for (int i = 0; i < NREQ; i++) drop[i] = 1'b0;
      for (int c = 0; c < 300 && !all_quiet(); c++) step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("drain_busy", 32'(busy), 32'd0);
      chk("drain_wr_left", 32'(exp_x_q.size()), 32'd0);
      chk("drain_cyc_left", 32'(exp_cyc_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/afifo_wr_arb.md
Name: afifo_wr_arb

Overview:
- Write-side arbiter for the async FIFO write port, in the wclk domain.
- Shares one FIFO write port among NREQ requesters using round-robin grants with a burst limit per grant.
- Drives the FIFO's wen and write data, and back-pressures requesters from the FIFO's registered full flag.

Parameters:
- DSIZE, 8, data width per requester and of the FIFO write port.
- ASIZE, 4, FIFO address width; sets the burst counter ceiling, MAXBURST ≤ 2**ASIZE.
- NREQ, 4, number of requesters, 2..8.
- MAXBURST, 4, maximum transfers per grant, 1..2**ASIZE.

Ports:
- wclk  in  1  write clock.
- wrst_n  in  1  async active-low reset.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*DSIZE  packed data; requester i occupies bits [i*DSIZE +: DSIZE].
- req_ready  out  NREQ  per-requester accept; a transfer occurs when valid & ready.
- full  in  1  FIFO full flag (registered at the FIFO).
- wen  out  1  FIFO write enable.
- wdata  out  DSIZE  FIFO write data.
- gnt_id  out  $clog2(NREQ)  index of the current grant holder; valid while busy=1.
- busy  out  1  high in GRANT state.

Behaviour:
- Reset (async, wrst_n=0):
  - state=IDLE, rr_ptr=0, burst_cnt=0, gnt_id=0.
  - busy=0, req_ready=0, wen=0, wdata=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Register it into gnt_id, go to GRANT, clear burst_cnt.
  - No transfer occurs in the IDLE cycle.
  - Arbitration latency is 1 cycle: the earliest transfer is the cycle after the request is seen.
- GRANT, combinational outputs:
  - req_ready[gnt_id] = ~full; all other req_ready bits = 0.
  - wen = req_valid[gnt_id] & ~full.
  - wdata = req_data slice gnt_id, muxed combinationally.
  - Data passes through with zero latency.
- GRANT, per-cycle update:
  - On a transfer, burst_cnt increments.
  - Release to IDLE on the next edge when either:
    - a transfer occurs with burst_cnt == MAXBURST-1, or
    - req_valid[gnt_id]=0 (nothing transferred that cycle).
  - On release, rr_ptr = gnt_id+1, wrapping at NREQ.
- full=1 while in GRANT:
  - Grant is held, no transfer, burst_cnt frozen.
  - The stall does not count toward the burst and does not release the grant, provided valid stays high.
- wen must never assert while full=1. The FIFO also gates its increment internally; this block must not depend on that.
- Requesters must hold req_valid and req_data until accepted. Dropping valid ends the grant.
- A simultaneous request from the current holder and others has no effect until release; fairness comes from rr_ptr rotation.
- If only one requester is active, it is re-granted after a 1-cycle IDLE bubble per burst.
- Reset mid-burst: all state clears immediately, and the partial burst is abandoned.
- NREQ not a power of two: rr_ptr wraps from NREQ-1 to 0; values ≥ NREQ are never reached.
- burst_cnt width is $clog2(MAXBURST+1).

Optional Feature:
- Macro: AFIFO_WR_ARB_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0].
  - Increments in every GRANT cycle where req_valid[gnt_id]=1 and full=1.
  - Saturates at 16'hFFFF; reset value 0.
  - Adds input stall_clr (1 bit), a synchronous clear. Clear wins over a simultaneous increment.
- When undefined: neither port exists, and there is no counter logic.

Decomposition:
- Package afifo_pkg:
  - arb_state_t enum {IDLE, GRANT}.
  - Function clog2_min1 (returns ≥1).
  - Localparam STALL_CNT_W=16.
- Sub-module rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: any, idx.
  - Instantiated once, in IDLE decode.

Test Plan:
- Single requester 0, valid held 10 cycles, MAXBURST=4, full=0 → transfers on cycles 1-4, 6-9, 11-12; IDLE bubble at cycles 5 and 10; wdata follows req_data slice 0.
- All 4 requesters valid continuously → grant order 0,1,2,3,0, each with exactly 4 wen pulses; gnt_id matches the data source.
- Requester 2 granted, full=1 asserted after its 2nd transfer for 3 cycles → wen=0 and req_ready=0 during the stall; the grant is held; 2 more transfers after full drops, then release.
- Requester 1 drops valid after 1 transfer → IDLE next cycle; rr_ptr=2; requester 2 is granted ahead of requester 0 when both are valid.
- Assert wrst_n=0 mid-burst for 1 cycle → wen, req_ready, busy, gnt_id all 0 asynchronously; after release, arbitration restarts from requester 0.
- With AFIFO_WR_ARB_STALL_CNT_EN: 5 stalled cycles → stall_cnt=5; stall_clr pulsed during a stall → stall_cnt=0 next cycle.
